// File: rtl/fetch_pkg.sv
// Shared types and defaults for the program fetch sequencer.
package fetch_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 8;
  localparam int NIB_W      = DATA_W_DEF / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/program_counter.sv
// Program counter: branch load beats increment; wrap pulses for the cycle after 2**ADDR_W-1 -> 0.
module program_counter #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (load) begin
        pc <= load_addr;
      end else if (inc) begin
        pc   <= pc + ADDR_W'(1);
        wrap <= &pc;
      end
    end
  end
endmodule

// File: rtl/program_fetch.sv
// Fetch sequencer: drives ROM address from the PC, captures the returned byte and
// offers it to the decoder as instr/oprnd nibbles under valid/ready.
module program_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROM_LAT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                load,
  input  logic [ADDR_W-1:0]   load_addr,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [DATA_W/2-1:0] instr,
  output logic [DATA_W/2-1:0] oprnd,
  output logic [ADDR_W-1:0]   fetch_pc,
  output logic                pc_wrap
);
  localparam int HALF = DATA_W / 2;

  fetch_state_e        state;
  logic [DATA_W-1:0]   fetch_reg;
  logic                cap;

  // Capture edge is ISSUE for a combinational ROM, WAIT for a registered one.
  assign cap = !load && ((state == ST_ISSUE && ROM_LAT == 0) || state == ST_WAIT);

  program_counter #(.ADDR_W(ADDR_W)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_addr (load_addr),
    .inc       (cap),
    .pc        (rom_addr),
    .wrap      (pc_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fetch_reg   <= '0;
      fetch_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (load) begin
      // Branch flushes whatever is in flight or held; a same-edge handshake still counts.
      state       <= enable ? ST_ISSUE : ST_IDLE;
      instr_valid <= 1'b0;
    end else begin
      if (cap) begin
        fetch_reg <= rom_data;
        fetch_pc  <= rom_addr;
      end
      case (state)
        ST_IDLE:  if (enable) state <= ST_ISSUE;
        ST_ISSUE: begin
          if (ROM_LAT == 0) begin
            state       <= ST_HOLD;
            instr_valid <= 1'b1;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state       <= ST_HOLD;
          instr_valid <= 1'b1;
        end
        ST_HOLD: begin
          if (instr_ready) begin
            state       <= enable ? ST_ISSUE : ST_IDLE;
            instr_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign instr = fetch_reg[DATA_W-1:HALF];
  assign oprnd = fetch_reg[HALF-1:0];
endmodule
